// File: rtl/boot_copier.sv
// Boot image copier: moves WORD_COUNT words flash->RAM one at a time via request/done handshakes; optional BOOT_CHECKSUM_EN sum check.
// Latency: 1 cycle RD entry + flash latency + 1 cycle + RAM latency per word (4 cycles minimum with single-cycle controllers).
// Backpressure: requests are levels held until the matching done pulse; a silent controller trips the wait timeout into ERR.
module boot_copier #(
    parameter int          FLASH_ADDR_W   = 22,
    parameter int          RAM_ADDR_W     = 18,
    parameter int          DATA_W         = 16,
    parameter int unsigned FLASH_BASE     = 0,
    parameter int unsigned RAM_BASE       = 0,
    parameter int          WORD_COUNT     = 538,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter int          AUTO_START     = 1,
    parameter int unsigned EXPECTED_SUM   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    flash_work_done,
    input  logic [DATA_W-1:0]       flash_data,
    input  logic                    ram_work_done,
    output logic                    flash_need_to_work,
    output logic [FLASH_ADDR_W:1]   flash_addr_out,
    output logic                    ram_need_to_work,
    output logic [RAM_ADDR_W-1:0]   ram_addr_out,
    output logic [DATA_W-1:0]       data_out,
    output logic                    boot_done_out,
    output logic                    boot_err_out,
    output logic                    busy_out
`ifdef BOOT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]       checksum_out
`endif
);

    localparam int IDX_W  = (WORD_COUNT < 1) ? 1 : $clog2(WORD_COUNT + 1);
    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX  = (WORD_COUNT < 1) ? '0 : IDX_W'(WORD_COUNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT_CYCLES < 1) ? '0 : WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam bit EMPTY      = (WORD_COUNT == 0);
    localparam bit AUTO       = (AUTO_START != 0);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_t;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]   data_q;
    logic                idx_clr, idx_inc, data_ld, timed_out, sum_ok;

    // A done pulse on the timeout cycle is checked first, so it wins.
    assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_nxt          = state;
        idx_clr            = 1'b0;
        idx_inc            = 1'b0;
        data_ld            = 1'b0;
        flash_need_to_work = 1'b0;
        ram_need_to_work   = 1'b0;
        boot_done_out      = 1'b0;
        boot_err_out       = 1'b0;
        busy_out           = 1'b0;
        case (state)
            S_IDLE: begin
                if (AUTO || start) begin
                    idx_clr   = 1'b1;
                    state_nxt = EMPTY ? S_DONE : S_RD;
                end
            end
            S_RD: begin
                flash_need_to_work = 1'b1;
                busy_out           = 1'b1;
                if (flash_work_done) begin
                    data_ld   = 1'b1;
                    state_nxt = S_WR;
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end
            end
            S_WR: begin
                ram_need_to_work = 1'b1;
                busy_out         = 1'b1;
                if (ram_work_done) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = sum_ok ? S_DONE : S_ERR;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = S_RD;
                    end
                end else if (timed_out) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                boot_done_out = 1'b1;
                if (start) begin
                    idx_clr   = 1'b1;
                    state_nxt = EMPTY ? S_DONE : S_RD;
                end
            end
            S_ERR: begin
                boot_err_out = 1'b1;
                if (start) begin
                    idx_clr   = 1'b1;
                    state_nxt = EMPTY ? S_DONE : S_RD;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (idx_clr) begin
            idx <= '0;
        end else if (idx_inc) begin
            idx <= idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else if (data_ld) begin
            data_q <= flash_data;
        end
    end

    // Every state change restarts the wait window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_nxt != state) begin
            wait_cnt <= '0;
        end else if (busy_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (idx_clr) begin
            sum <= '0;
        end else if (data_ld) begin
            sum <= sum + flash_data;
        end
    end

    assign sum_ok       = (sum == DATA_W'(EXPECTED_SUM));
    assign checksum_out = sum;
`else
    logic unused_expected_sum;

    assign sum_ok              = 1'b1;
    assign unused_expected_sum = ^DATA_W'(EXPECTED_SUM);
`endif

    assign flash_addr_out = FLASH_ADDR_W'(FLASH_BASE) + FLASH_ADDR_W'(idx);
    assign ram_addr_out   = RAM_ADDR_W'(RAM_BASE) + RAM_ADDR_W'(idx);
    assign data_out       = data_q;

endmodule

// File: tb/tb_boot_copier.sv
// Self-checking bench for boot_copier: randomized latencies/data against a word-list reference model.
module tb_boot_copier;

    localparam int WC  = 4;
    localparam int FB  = 32'h100;
    localparam int RB  = 32'h20;
    localparam int TO  = 16;
    localparam int EXP = 32'h0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flash_work_done = 1'b0;
    logic [15:0] flash_data = '0;
    logic        ram_work_done = 1'b0;
    logic        flash_need_to_work;
    logic [22:1] flash_addr_out;
    logic        ram_need_to_work;
    logic [17:0] ram_addr_out;
    logic [15:0] data_out;
    logic        boot_done_out;
    logic        boot_err_out;
    logic        busy_out;
`ifdef BOOT_CHECKSUM_EN
    logic [15:0] checksum_out;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    boot_copier #(
        .FLASH_ADDR_W(22), .RAM_ADDR_W(18), .DATA_W(16),
        .FLASH_BASE(FB), .RAM_BASE(RB), .WORD_COUNT(WC),
        .TIMEOUT_CYCLES(TO), .AUTO_START(0), .EXPECTED_SUM(EXP)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .flash_work_done(flash_work_done), .flash_data(flash_data),
        .ram_work_done(ram_work_done),
        .flash_need_to_work(flash_need_to_work), .flash_addr_out(flash_addr_out),
        .ram_need_to_work(ram_need_to_work), .ram_addr_out(ram_addr_out),
        .data_out(data_out), .boot_done_out(boot_done_out),
        .boot_err_out(boot_err_out), .busy_out(busy_out)
`ifdef BOOT_CHECKSUM_EN
        , .checksum_out(checksum_out)
`endif
    );

    function automatic logic [21:0] fa(input int i);
        return 22'(FB + i);
    endfunction

    function automatic logic [17:0] ra(input int i);
        return 18'(RB + i);
    endfunction

    // Acts as both controllers for one word; mode 1 injects stray pulses, mode 2 a start during RD.
    task automatic serve_word(input int idx, input int fl_lat, input int ram_lat, input logic [15:0] w, input int mode);
        int n = 0;
        logic [15:0] junk;
        junk = ~w;
        while (flash_need_to_work !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (flash_need_to_work !== 1'b1 || ram_need_to_work !== 1'b0 || flash_addr_out !== fa(idx) || busy_out !== 1'b1) begin
            bad++;
            $display("FAIL rd_entry w%0d: req=%b ram_req=%b addr=%h busy=%b, required 1 0 %h 1",
                     idx, flash_need_to_work, ram_need_to_work, flash_addr_out, busy_out, fa(idx));
        end
        for (int k = 1; k <= fl_lat; k++) begin
            @(negedge clk);
            ram_work_done = (mode == 1 && k == 1);
            start         = (mode == 2 && k == 1);
            total++;
            if (flash_need_to_work !== 1'b1 || ram_need_to_work !== 1'b0 || flash_addr_out !== fa(idx)) begin
                bad++;
                $display("FAIL rd_hold w%0d k%0d: req=%b ram_req=%b addr=%h, required 1 0 %h",
                         idx, k, flash_need_to_work, ram_need_to_work, flash_addr_out, fa(idx));
            end
        end
        ram_work_done   = 1'b0;
        start           = 1'b0;
        flash_data      = w;
        flash_work_done = 1'b1;
        @(negedge clk);
        flash_work_done = 1'b0;
        flash_data      = 16'($urandom);
        total++;
        if (flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b1 || ram_addr_out !== ra(idx) || data_out !== w) begin
            bad++;
            $display("FAIL wr_entry w%0d: req=%b ram_req=%b ram_addr=%h data=%h, required 0 1 %h %h",
                     idx, flash_need_to_work, ram_need_to_work, ram_addr_out, data_out, ra(idx), w);
        end
        for (int k = 1; k <= ram_lat; k++) begin
            @(negedge clk);
            flash_work_done = (mode == 1 && k == 1);
            flash_data      = junk;
            total++;
            if (ram_need_to_work !== 1'b1 || flash_need_to_work !== 1'b0 || ram_addr_out !== ra(idx) || data_out !== w) begin
                bad++;
                $display("FAIL wr_hold w%0d k%0d: ram_req=%b req=%b ram_addr=%h data=%h, required 1 0 %h %h",
                         idx, k, ram_need_to_work, flash_need_to_work, ram_addr_out, data_out, ra(idx), w);
            end
        end
        ram_work_done   = 1'b1;
        flash_work_done = (mode == 1);
        flash_data      = junk;
        @(negedge clk);
        ram_work_done   = 1'b0;
        flash_work_done = 1'b0;
    endtask

    // Full copy from a start pulse; latency < 0 means random 0..15 per word.
    task automatic run_copy(input logic [15:0] words [WC], input int fl_lat, input int ram_lat,
                            input int mode_word, input int mode);
        logic [15:0] sum = '0;
        logic ok;
        int fl, rl;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (flash_need_to_work !== 1'b1 || boot_done_out !== 1'b0 || boot_err_out !== 1'b0) begin
            bad++;
            $display("FAIL start_resp: req=%b done=%b err=%b, required 1 0 0", flash_need_to_work, boot_done_out, boot_err_out);
        end
        for (int i = 0; i < WC; i++) begin
            fl = (fl_lat < 0) ? int'($urandom_range(0, 15)) : fl_lat;
            rl = (ram_lat < 0) ? int'($urandom_range(0, 15)) : ram_lat;
            if (i == mode_word) begin
                fl = 4;
                rl = 4;
            end
            serve_word(i, fl, rl, words[i], (i == mode_word) ? mode : 0);
            sum += words[i];
        end
`ifdef BOOT_CHECKSUM_EN
        ok = (sum == 16'(EXP));
`else
        ok = 1'b1;
`endif
        total++;
        if (boot_done_out !== ok || boot_err_out !== !ok || busy_out !== 1'b0 || flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b0) begin
            bad++;
            $display("FAIL copy_end: done=%b err=%b busy=%b reqs=%b%b, required %b %b 0 00 (sum=%h)",
                     boot_done_out, boot_err_out, busy_out, flash_need_to_work, ram_need_to_work, ok, !ok, sum);
        end
`ifdef BOOT_CHECKSUM_EN
        total++;
        if (checksum_out !== sum) begin
            bad++;
            $display("FAIL checksum: got %h, required %h", checksum_out, sum);
        end
`endif
    endtask

    task automatic rand_words(output logic [15:0] w [WC]);
        for (int i = 0; i < WC; i++) w[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b0 || boot_done_out !== 1'b0 || boot_err_out !== 1'b0 ||
            busy_out !== 1'b0 || data_out !== 16'h0 || flash_addr_out !== fa(0) || ram_addr_out !== ra(0)) begin
            bad++;
            $display("FAIL reset_state: reqs=%b%b done=%b err=%b busy=%b data=%h fa=%h ra=%h, required 00 0 0 0 0000 %h %h",
                     flash_need_to_work, ram_need_to_work, boot_done_out, boot_err_out, busy_out, data_out,
                     flash_addr_out, ram_addr_out, fa(0), ra(0));
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            total++;
            if (flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b0 || busy_out !== 1'b0 || boot_done_out !== 1'b0) begin
                bad++;
                $display("FAIL no_autostart c%0d: reqs=%b%b busy=%b done=%b, required 00 0 0",
                         c, flash_need_to_work, ram_need_to_work, busy_out, boot_done_out);
            end
        end
    endtask

    task automatic test_copy_basic();
        logic [15:0] w [WC];
        rand_words(w);
        run_copy(w, 2, 2, -1, 0);
    endtask

    task automatic test_start_ignored();
        logic [15:0] w [WC];
        rand_words(w);
        run_copy(w, -1, -1, 2, 2);
    endtask

    task automatic test_stray_pulses();
        logic [15:0] w [WC];
        rand_words(w);
        run_copy(w, -1, -1, 1, 1);
    endtask

    task automatic test_timeout();
        logic [15:0] w [WC];
        int n = 0;
        rand_words(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_word(0, 3, 2, w[0], 0);
        total++;
        if (flash_need_to_work !== 1'b1 || flash_addr_out !== fa(1)) begin
            bad++;
            $display("FAIL to_req: req=%b addr=%h, required 1 %h", flash_need_to_work, flash_addr_out, fa(1));
        end
        while (boot_err_out !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n != TO) begin
            bad++;
            $display("FAIL timeout_cycles: err after %0d cycles, required %0d", n, TO);
        end
        repeat (3) @(negedge clk);
        total++;
        if (boot_err_out !== 1'b1 || flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b0 || busy_out !== 1'b0 || boot_done_out !== 1'b0) begin
            bad++;
            $display("FAIL timeout_hold: err=%b reqs=%b%b busy=%b done=%b, required 1 00 0 0",
                     boot_err_out, flash_need_to_work, ram_need_to_work, busy_out, boot_done_out);
        end
        rand_words(w);
        run_copy(w, -1, -1, -1, 0);
    endtask

    task automatic test_timeout_edge();
        logic [15:0] w [WC];
        rand_words(w);
        run_copy(w, TO - 1, TO - 1, -1, 0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w [WC];
        rand_words(w);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        serve_word(0, 1, 1, w[0], 0);
        serve_word(1, 1, 1, 16'hA5A5, 0);
        @(negedge clk);
        total++;
        if (flash_need_to_work !== 1'b1 || flash_addr_out !== fa(2) || data_out !== 16'hA5A5) begin
            bad++;
            $display("FAIL pre_reset: req=%b addr=%h data=%h, required 1 %h a5a5", flash_need_to_work, flash_addr_out, data_out, fa(2));
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (flash_need_to_work !== 1'b0 || ram_need_to_work !== 1'b0 || busy_out !== 1'b0 || data_out !== 16'h0 ||
            boot_done_out !== 1'b0 || boot_err_out !== 1'b0 || flash_addr_out !== fa(0) || ram_addr_out !== ra(0)) begin
            bad++;
            $display("FAIL async_reset: reqs=%b%b busy=%b data=%h done=%b err=%b fa=%h ra=%h, required 00 0 0000 0 0 %h %h",
                     flash_need_to_work, ram_need_to_work, busy_out, data_out, boot_done_out, boot_err_out,
                     flash_addr_out, ram_addr_out, fa(0), ra(0));
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (busy_out !== 1'b0 || flash_need_to_work !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle: busy=%b req=%b, required 0 0", busy_out, flash_need_to_work);
        end
        run_copy(w, -1, -1, -1, 0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [WC];
        for (int r = 0; r < 6; r++) begin
            rand_words(w);
            run_copy(w, (r == 0) ? 0 : -1, (r == 0) ? 0 : -1, -1, 0);
        end
    endtask

    task automatic test_checksum();
        logic [15:0] w [WC];
        w = '{16'h0001, 16'h0002, 16'hFFFF, 16'h0000};
        run_copy(w, 1, 1, -1, 0);
        w = '{16'h0001, 16'h0002, 16'hFFFF, 16'h0001};
        run_copy(w, 1, 1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_copy_basic();
        test_start_ignored();
        test_stray_pulses();
        test_timeout();
        test_timeout_edge();
        test_reset_mid();
        test_back_to_back();
        test_checksum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_copier.md
Name: boot_copier

Overview:
- Parametrised flash-to-RAM boot image copier; next generation of the fixed-length bootloader.
- Copies WORD_COUNT words from flash, starting at FLASH_BASE, into RAM starting at RAM_BASE, one word at a time, using request/done handshakes with the flash and RAM controllers.
- Adds: configurable base addresses and length, restart on demand, per-transfer timeout with error flag, optional checksum verification.
- Sits between the flash controller, the RAM controller and the CPU reset/hold logic. boot_done_out releases the CPU.

Parameters:
- FLASH_ADDR_W, 22, flash word-address width (flash_addr_out spans [FLASH_ADDR_W:1]).
- RAM_ADDR_W, 18, RAM word-address width.
- DATA_W, 16, data word width.
- FLASH_BASE, 0, first flash word address.
- RAM_BASE, 0, first RAM word address.
- WORD_COUNT, 538, number of words to copy (0 allowed).
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for any done pulse (0 disables the timeout).
- AUTO_START, 1, when 1 the copy begins automatically after reset.
- EXPECTED_SUM, 0, checksum reference (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle pulse; starts or restarts a copy from IDLE, DONE or ERR.
- flash_work_done  in  1  one-cycle pulse: flash read complete, flash_data valid.
- flash_data  in  DATA_W  flash read data.
- ram_work_done  in  1  one-cycle pulse: RAM write complete.
- flash_need_to_work  out  1  flash read request, level.
- flash_addr_out  out  FLASH_ADDR_W  flash word address (bits [FLASH_ADDR_W:1]).
- ram_need_to_work  out  1  RAM write request, level.
- ram_addr_out  out  RAM_ADDR_W  RAM write address.
- data_out  out  DATA_W  word to write.
- boot_done_out  out  1  copy finished successfully; held until restart or reset.
- boot_err_out  out  1  timeout (or checksum mismatch); held until restart or reset.
- busy_out  out  1  high in RD or WR.

Behaviour:
- Reset (async, rst=1): state IDLE, index=0, all outputs 0. The address outputs show base+0 (FLASH_BASE and RAM_BASE).
- States: IDLE, RD, WR, DONE, ERR.
- IDLE: moves to RD on the first clock after rst deasserts if AUTO_START=1; otherwise moves to RD on start. If WORD_COUNT==0, goes to DONE instead, with no requests issued.
- RD: flash_need_to_work=1, flash_addr_out=FLASH_BASE+index.
  - On flash_work_done: latch data_out<=flash_data, drop flash_need_to_work, go to WR. Request rises on the next cycle.
- WR: ram_need_to_work=1, ram_addr_out=RAM_BASE+index.
  - On ram_work_done with index==WORD_COUNT-1: drop the request, go to DONE.
  - On ram_work_done otherwise: drop the request, increment index, go to RD.
- Request and address contract:
  - Requests are levels, held until the matching done pulse is sampled.
  - Addresses and data are stable while a request is high.
  - At most one request is high at any time.
- Wait counter:
  - Clears on every state entry and increments each cycle in RD/WR.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no done pulse, go to ERR, drop all requests, set boot_err_out.
  - A done pulse arriving on the same cycle as the timeout wins: the transfer completes normally.
- Done pulse in the wrong state (ram_work_done in RD, flash_work_done in WR or IDLE): ignored. Both pulses on one cycle: only the one matching the state acts.
- DONE: boot_done_out=1.
- DONE or ERR plus start: clear flags, index and checksum; go to RD.
- start while busy: ignored.
- Address arithmetic: base+index truncated to the port width (wraps mod 2^W). The index counter is $clog2(WORD_COUNT+1) bits, minimum 1.
- Latency per word: 1 cycle RD entry, then flash latency, then 1 cycle, then RAM latency. Minimum 4 cycles per word with single-cycle controllers.
- Reset mid-copy: immediate return to reset values. The copy then restarts from index 0 per AUTO_START.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- With the macro defined:
  - A DATA_W-bit running sum (mod 2^DATA_W) of every latched flash word is kept and output on an extra port, checksum_out (out, DATA_W).
  - On the final ram_work_done: go to DONE if sum==EXPECTED_SUM, else go to ERR.
  - The sum clears on reset and on restart.
- Without the macro: no checksum_out port, no sum logic, and the final word always goes to DONE.

Test Plan:
- WORD_COUNT=4, FLASH_BASE=0x100, RAM_BASE=0x20, done pulses 2 cycles after each request:
  - Flash addresses 0x100–0x103 and RAM addresses 0x20–0x23 in order; data_out matches flash_data.
  - boot_done_out=1 after the 4th ram_work_done; boot_err_out=0.
- AUTO_START=0:
  - No request appears for 50 cycles.
  - start pulse: flash_need_to_work=1 on the next cycle.
  - A start pulse during RD is ignored (index unchanged).
- TIMEOUT_CYCLES=16, flash never responds: boot_err_out=1 exactly 16 cycles after the request rises; requests drop. A later start restarts at index 0.
- Stray pulses: ram_work_done during RD, and both done pulses on one cycle during WR. No extra index advance, no data change; the word completes normally.
- rst=1 asserted during word 2 of 4, not clock-aligned:
  - Outputs go to 0 immediately; both address outputs return to base+0.
  - The recopy starts at index 0 and finishes with boot_done_out=1.
- BOOT_CHECKSUM_EN with words 0x0001, 0x0002, 0xFFFF:
  - EXPECTED_SUM=0x0002: DONE, checksum_out=0x0002.
  - EXPECTED_SUM=0x0003: ERR, boot_done_out=0.
